// File: rtl/camera_cfg_master.sv
// rtl/camera_cfg_master.sv - Avalon-MM master that programs and optionally verifies a camera register block
module camera_cfg_master #(
    parameter int READ_LATENCY = 1,
    parameter bit VERIFY       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [15:0] cfg_start_row,
    input  logic [15:0] cfg_start_column,
    input  logic [15:0] cfg_row_size,
    input  logic [15:0] cfg_column_size,
    input  logic [15:0] cfg_row_mode,
    input  logic [15:0] cfg_column_mode,
    input  logic [15:0] cfg_exposure,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  error_addr
);

    typedef enum logic [2:0] {
        IDLE, RST_ASSERT, WRITE, RST_RELEASE, READ_REQ, READ_WAIT, DONE
    } state_t;

    localparam logic [4:0] SOFT_RST_ADDR = 5'h1F;
    localparam logic [3:0] LAST_IDX      = 4'd8;
    localparam logic [1:0] LAT_LAST      = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  lat_q, lat_d;
    logic [15:0] cfg_q [9];
    logic [15:0] cfg_d [9];
    logic [15:0] cfg_in [9];
    logic        error_q, error_d;
    logic [4:0]  error_addr_q, error_addr_d;
    logic [15:0] cur_cfg;
    logic        readdata_unused;

    always_comb begin
        cfg_in[0] = cfg_width;
        cfg_in[1] = cfg_height;
        cfg_in[2] = cfg_start_row;
        cfg_in[3] = cfg_start_column;
        cfg_in[4] = cfg_row_size;
        cfg_in[5] = cfg_column_size;
        cfg_in[6] = cfg_row_mode;
        cfg_in[7] = cfg_column_mode;
        cfg_in[8] = cfg_exposure;
    end

    assign cur_cfg         = cfg_q[idx_q];
    // Only the low half of each camera register is meaningful on readback.
    assign readdata_unused = ^avm_readdata[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            lat_q        <= '0;
            error_q      <= 1'b0;
            error_addr_q <= '0;
            for (int i = 0; i < 9; i++) cfg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            error_q      <= error_d;
            error_addr_q <= error_addr_d;
            cfg_q        <= cfg_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lat_d         = lat_q;
        cfg_d         = cfg_q;
        error_d       = error_q;
        error_addr_d  = error_addr_q;
        avm_address   = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d        = cfg_in;
                    error_d      = 1'b0;
                    error_addr_d = '0;
                    idx_d        = '0;
                    state_d      = RST_ASSERT;
                end
            end
            RST_ASSERT: begin
                avm_write   = 1'b1;
                avm_address = SOFT_RST_ADDR;
                if (!avm_waitrequest) begin
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                avm_write     = 1'b1;
                avm_address   = {1'b0, idx_q};
                avm_writedata = {16'h0000, cur_cfg};
                if (!avm_waitrequest) begin
                    if (idx_q == LAST_IDX) state_d = RST_RELEASE;
                    else                   idx_d   = idx_q + 4'd1;
                end
            end
            RST_RELEASE: begin
                avm_write     = 1'b1;
                avm_address   = SOFT_RST_ADDR;
                avm_writedata = 32'h0000_0001;
                if (!avm_waitrequest) begin
                    if (VERIFY) begin
                        idx_d   = '0;
                        state_d = READ_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ_REQ: begin
                avm_read    = 1'b1;
                avm_address = {1'b0, idx_q};
                if (!avm_waitrequest) begin
                    lat_d   = '0;
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // The slave's data is valid only in the last cycle of the latency window.
                if (lat_q == LAT_LAST) begin
                    if (avm_readdata[15:0] != cur_cfg) begin
                        error_d      = 1'b1;
                        error_addr_d = {1'b0, idx_q};
                        state_d      = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = READ_REQ;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign error      = error_q;
    assign error_addr = error_addr_q;

endmodule

// File: tb/tb_camera_cfg_master.sv
// tb/tb_camera_cfg_master.sv - Randomized self-checking bench for camera_cfg_master
module tb_camera_cfg_master;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [15:0] cfg [9];

    logic [4:0]  a_addr, b_addr, a_eaddr, b_eaddr;
    logic        a_rd, a_wr, b_rd, b_wr, a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [31:0] a_wd, b_wd, a_rdd;
    logic        a_wait = 1'b0;
    logic [31:0] b_rdd  = 32'hDEAD_BEEF;
    logic        b_wait = 1'b0;

    always #5 clk = ~clk;

    camera_cfg_master #(.READ_LATENCY(1), .VERIFY(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_width(cfg[0]), .cfg_height(cfg[1]), .cfg_start_row(cfg[2]),
        .cfg_start_column(cfg[3]), .cfg_row_size(cfg[4]), .cfg_column_size(cfg[5]),
        .cfg_row_mode(cfg[6]), .cfg_column_mode(cfg[7]), .cfg_exposure(cfg[8]),
        .avm_address(a_addr), .avm_read(a_rd), .avm_write(a_wr), .avm_writedata(a_wd),
        .avm_readdata(a_rdd), .avm_waitrequest(a_wait),
        .busy(a_busy), .done(a_done), .error(a_err), .error_addr(a_eaddr));

    camera_cfg_master #(.READ_LATENCY(3), .VERIFY(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_width(cfg[0]), .cfg_height(cfg[1]), .cfg_start_row(cfg[2]),
        .cfg_start_column(cfg[3]), .cfg_row_size(cfg[4]), .cfg_column_size(cfg[5]),
        .cfg_row_mode(cfg[6]), .cfg_column_mode(cfg[7]), .cfg_exposure(cfg[8]),
        .avm_address(b_addr), .avm_read(b_rd), .avm_write(b_wr), .avm_writedata(b_wd),
        .avm_readdata(b_rdd), .avm_waitrequest(b_wait),
        .busy(b_busy), .done(b_done), .error(b_err), .error_addr(b_eaddr));

    // Slave model and bus monitor
    logic [31:0] mem [32];
    logic [37:0] log_a[$], log_b[$], exp_q[$];
    int          cyc = 0, hold_err = 0, w4_cycles = 0, b_reads = 0;
    int          stall_addr = -1, stall_left = 0, corrupt_addr = -1;
    logic [15:0] corrupt_val = '0;
    logic        p_stall = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_wd = '0;

    always @(negedge clk) begin
        a_wait = a_wr && (int'(a_addr) == stall_addr) && (stall_left > 0);
        if (a_wait) stall_left = stall_left - 1;
        if (a_wr && a_addr == 5'd4) w4_cycles = w4_cycles + 1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (p_stall && (a_addr !== p_addr || a_wd !== p_wd || a_wr !== 1'b1)) hold_err <= hold_err + 1;
        p_stall <= a_wait && a_wr;
        p_addr  <= a_addr;
        p_wd    <= a_wd;
        if (a_wr && !a_wait) begin
            mem[a_addr] <= a_wd;
            log_a.push_back({1'b1, a_addr, a_wd});
        end
        if (a_rd && !a_wait) begin
            log_a.push_back({1'b0, a_addr, 32'h0});
            if (int'(a_addr) == corrupt_addr) a_rdd <= {16'hABCD, corrupt_val};
            else                              a_rdd <= {16'($urandom), mem[a_addr][15:0]};
        end
        if (b_wr) log_b.push_back({1'b1, b_addr, b_wd});
        if (b_rd) b_reads <= b_reads + 1;
    end

    int n_cmp = 0, n_bad = 0;
    logic [37:0] exp_err_q;
    bit          exp_err;
    logic [4:0]  exp_eaddr;
    int          exp_n;
    int          got_n;
    bit          timed_out, first_ok, err_after_start, busy_at_done, after_busy, after_done;

    task automatic randomize_cfg();
        for (int i = 0; i < 9; i++) cfg[i] = 16'($urandom);
    endtask

    // Reference: transfer list, outcome and latency derived straight from the protocol rules.
    task automatic build_exp(input bit verify, input int lat, input int stalls,
                             input int bad_addr, input logic [15:0] bad_val);
        int nreads = 0;
        exp_q.delete();
        exp_q.push_back({1'b1, 5'h1F, 32'h0});
        for (int i = 0; i < 9; i++) exp_q.push_back({1'b1, 5'(i), 16'h0, cfg[i]});
        exp_q.push_back({1'b1, 5'h1F, 32'h1});
        exp_err = 1'b0;
        exp_eaddr = '0;
        if (verify) begin
            for (int i = 0; i < 9; i++) begin
                exp_q.push_back({1'b0, 5'(i), 32'h0});
                nreads++;
                if (i == bad_addr && bad_val != cfg[i]) begin
                    exp_err = 1'b1;
                    exp_eaddr = 5'(i);
                    break;
                end
            end
        end
        exp_n = 11 + nreads * (1 + lat) + 1 + stalls;
    endtask

    task automatic run_seq(input bit watch_b, input bit disturb);
        int s;
        log_a.delete();
        log_b.delete();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        start = 1'b0;
        timed_out = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) begin
                first_ok = (a_wr === 1'b1 && a_addr === 5'h1F && a_wd === 32'h0);
                err_after_start = a_err;
            end
            if (disturb && n == 5) begin
                start = 1'b1;
                randomize_cfg();
            end
            if (disturb && n == 6) start = 1'b0;
            if (watch_b ? b_done : a_done) begin
                got_n = cyc - s + 1;
                busy_at_done = watch_b ? b_busy : a_busy;
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
        after_busy = watch_b ? b_busy : a_busy;
        after_done = watch_b ? b_done : a_done;
        for (int n = 0; n < 100 && (a_busy || b_busy); n++) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({a_rd, a_wr, a_addr, a_wd, a_busy, a_done, a_err, a_eaddr} !== 47'h0) begin
            n_bad++;
            $display("FAIL reset_a: got %0h required 0", {a_rd, a_wr, a_addr, a_wd, a_busy, a_done, a_err, a_eaddr});
        end
        n_cmp++;
        if ({b_rd, b_wr, b_addr, b_wd, b_busy, b_done, b_err, b_eaddr} !== 47'h0) begin
            n_bad++;
            $display("FAIL reset_b: got %0h required 0", {b_rd, b_wr, b_addr, b_wd, b_busy, b_done, b_err, b_eaddr});
        end
    endtask

    task automatic test_defaults();
        int d = 0;
        randomize_cfg();
        cfg[0] = 16'd320; cfg[1] = 16'd240; cfg[2] = 16'h0036;
        corrupt_addr = -1;
        build_exp(1'b1, 1, 0, -1, '0);
        run_seq(1'b0, 1'b0);
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL defaults_latency: got %0d required %0d (timeout %0d)", got_n, exp_n, timed_out); end
        n_cmp++; if (!first_ok) begin n_bad++; $display("FAIL defaults_first_write: got 0 required 1"); end
        foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL defaults_log: %0d differ, got %0d transfers required %0d", d, log_a.size(), exp_q.size()); end
        n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL defaults_error: got %0b required 0", a_err); end
        n_cmp++; if (busy_at_done !== 1'b1 || after_busy !== 1'b0 || after_done !== 1'b0) begin n_bad++; $display("FAIL defaults_busy_done: got %0b%0b%0b required 100", busy_at_done, after_busy, after_done); end
    endtask

    task automatic test_stall();
        int d = 0, h0 = hold_err, w0;
        randomize_cfg();
        stall_addr = 4; stall_left = 3;
        build_exp(1'b1, 1, 3, -1, '0);
        w0 = w4_cycles;
        run_seq(1'b0, 1'b0);
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL stall_latency: got %0d required %0d", got_n, exp_n); end
        n_cmp++; if (w4_cycles - w0 !== 4) begin n_bad++; $display("FAIL stall_visible_cycles: got %0d required 4", w4_cycles - w0); end
        n_cmp++; if (hold_err - h0 !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes required 0", hold_err - h0); end
        foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_log: %0d differ, got %0d transfers required %0d", d, log_a.size(), exp_q.size()); end
        stall_addr = -1;
    endtask

    task automatic test_mismatch();
        int d = 0;
        randomize_cfg();
        cfg[5] = 16'h077F;
        corrupt_addr = 5; corrupt_val = 16'h1234;
        build_exp(1'b1, 1, 0, 5, 16'h1234);
        run_seq(1'b0, 1'b0);
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL mismatch_latency: got %0d required %0d", got_n, exp_n); end
        n_cmp++; if (a_err !== 1'b1 || a_eaddr !== 5'h05) begin n_bad++; $display("FAIL mismatch_error: got %0b/%0h required 1/5", a_err, a_eaddr); end
        foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL mismatch_log: %0d differ, got %0d transfers required %0d", d, log_a.size(), exp_q.size()); end
        repeat (4) @(negedge clk);
        n_cmp++; if (a_err !== 1'b1 || a_eaddr !== 5'h05) begin n_bad++; $display("FAIL mismatch_hold: got %0b/%0h required 1/5", a_err, a_eaddr); end
        corrupt_addr = -1;
    endtask

    task automatic test_ignore_start();
        int d = 0;
        randomize_cfg();
        build_exp(1'b1, 1, 0, -1, '0);
        run_seq(1'b0, 1'b1);
        n_cmp++; if (err_after_start !== 1'b0) begin n_bad++; $display("FAIL start_clears_error: got %0b required 0", err_after_start); end
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL ignore_start_latency: got %0d required %0d", got_n, exp_n); end
        foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL ignore_start_log: %0d differ, got %0d transfers required %0d", d, log_a.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int d = 0;
        randomize_cfg();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (a_rd && a_addr == 5'd3) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL reset_mid_reach_read3: got 0 required 1"); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_rd, a_wr, a_addr, a_wd, a_busy, a_done, a_err, a_eaddr} !== 47'h0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %0h required 0", {a_rd, a_wr, a_addr, a_wd, a_busy, a_done, a_err, a_eaddr});
        end
        @(negedge clk) reset_n = 1'b1;
        log_a.delete();
        repeat (5) @(negedge clk);
        n_cmp++; if (log_a.size() != 0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_no_restart: got %0d transfers busy %0b required 0/0", log_a.size(), a_busy); end
        randomize_cfg();
        build_exp(1'b1, 1, 0, -1, '0);
        run_seq(1'b0, 1'b0);
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL reset_mid_rerun_latency: got %0d required %0d", got_n, exp_n); end
        foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL reset_mid_rerun_log: %0d differ, got %0d transfers required %0d", d, log_a.size(), exp_q.size()); end
    endtask

    task automatic test_verify0();
        int d = 0, r0 = b_reads;
        randomize_cfg();
        build_exp(1'b0, 3, 0, -1, '0);
        run_seq(1'b1, 1'b0);
        n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL verify0_latency: got %0d required %0d", got_n, exp_n); end
        n_cmp++; if (b_reads - r0 !== 0) begin n_bad++; $display("FAIL verify0_no_reads: got %0d required 0", b_reads - r0); end
        foreach (exp_q[i]) if (i >= log_b.size() || log_b[i] !== exp_q[i]) d++;
        n_cmp++; if (d != 0 || log_b.size() != exp_q.size()) begin n_bad++; $display("FAIL verify0_log: %0d differ, got %0d transfers required %0d", d, log_b.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 5; it++) begin
            int d = 0, slen, ca;
            logic [15:0] cv = '0;
            randomize_cfg();
            slen = $urandom_range(0, 3);
            stall_addr = $urandom_range(0, 9);
            if (stall_addr == 9) stall_addr = 31;
            stall_left = slen;
            ca = -1;
            if ($urandom_range(0, 1) == 1) begin
                ca = $urandom_range(0, 8);
                cv = cfg[ca] ^ 16'($urandom_range(1, 65535));
            end
            corrupt_addr = ca;
            corrupt_val = cv;
            build_exp(1'b1, 1, slen, ca, cv);
            run_seq(1'b0, 1'b0);
            n_cmp++; if (timed_out || got_n !== exp_n) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", it, got_n, exp_n); end
            n_cmp++; if (a_err !== exp_err || (exp_err && a_eaddr !== exp_eaddr)) begin n_bad++; $display("FAIL b2b_error[%0d]: got %0b/%0h required %0b/%0h", it, a_err, a_eaddr, exp_err, exp_eaddr); end
            foreach (exp_q[i]) if (i >= log_a.size() || log_a[i] !== exp_q[i]) d++;
            n_cmp++; if (d != 0 || log_a.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_log[%0d]: %0d differ, got %0d transfers required %0d", it, d, log_a.size(), exp_q.size()); end
        end
        stall_addr = -1;
        stall_left = 0;
        corrupt_addr = -1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 9; i++) cfg[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_defaults();
        test_stall();
        test_mismatch();
        test_ignore_start();
        test_reset_mid();
        test_verify0();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
